lsu_sram_bridge: RTL and testbench

- Sits between the load/store unit's single-cycle data RAM port and the core's SRAM-like data bus. The bus uses a req/addr_ok request phase and a data_ok response phase.
- Converts each EX-stage access into one bus transaction and stalls the pipeline until the transaction completes.
- Aligns byte/halfword lanes on both the write and read paths.
- Registers read data so the load/store unit sees it, right-justified, during the load's MEM-stage cycle.

---
 rtl/lsu_sram_bridge_pkg.sv | 15 +
 rtl/lsu_sram_bridge_lane.sv | 36 +++
 rtl/lsu_sram_bridge.sv | 125 ++++++++++++
 tb/tb_lsu_sram_bridge.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_sram_bridge_pkg.sv
// Shared types and codes for the LSU-to-SRAM-bus bridge.
package lsu_sram_bridge_pkg;

  typedef enum logic [1:0] {
    BRG_IDLE = 2'd0,
    BRG_REQ  = 2'd1,
    BRG_WAIT = 2'd2,
    BRG_DONE = 2'd3
  } brg_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/lsu_sram_bridge_lane.sv
// Lane alignment: forms bus size/strobe/address from LSU byte enables and
// right-justifies returned read data by the captured byte offset.
module lsu_lane_align
  import lsu_sram_bridge_pkg::*;
(
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [1:0]  rd_off,
  input  logic [31:0] bus_rdata,
  output logic        wr,
  output logic [1:0]  size,
  output logic [3:0]  wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] rdata_shifted
);

  logic [1:0] off;
  assign off = addr[1:0];

  always_comb begin
    wr       = |wen;
    size     = SZ_WORD;
    wstrb    = 4'b0000;
    bus_addr = {addr[31:2], 2'b00};
    if (wr) begin
      bus_addr = addr;
      wstrb    = wen << off;
      if (wen[3])      size = SZ_WORD;
      else if (wen[1]) size = SZ_HALF;
      else             size = SZ_BYTE;
    end
  end

  assign rdata_shifted = bus_rdata >> {rd_off, 3'b000};

endmodule

// File: rtl/lsu_sram_bridge.sv
// Converts single-cycle LSU data RAM accesses into req/addr_ok/data_ok bus
// transactions, stalling the pipeline until each one completes.
//
// state     | meaning
// BRG_IDLE  | no transaction; capture a new EX access
// BRG_REQ   | request asserted, waiting for addr_ok
// BRG_WAIT  | request accepted, waiting for data_ok
// BRG_DONE  | access complete; pipeline advances EX->MEM this cycle
module lsu_sram_bridge
  import lsu_sram_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ram_en,
  input  logic [3:0]  data_ram_wen,
  input  logic [31:0] data_ram_addr,
  input  logic [31:0] data_ram_wdata,
  output logic [31:0] data_ram_rdata,
  input  logic        flush,
  output logic        stall_req,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);

  brg_state_t  state, state_nxt;
  logic        cancel, cancel_nxt;
  logic        capture, resp, cancel_eff;
  logic [1:0]  off_q;

  logic        fm_wr;
  logic [1:0]  fm_size;
  logic [3:0]  fm_wstrb;
  logic [31:0] fm_addr, rdata_shifted;

  lsu_lane_align u_lane (
    .wen           (data_ram_wen),
    .addr          (data_ram_addr),
    .rd_off        (off_q),
    .bus_rdata     (data_sram_rdata),
    .wr            (fm_wr),
    .size          (fm_size),
    .wstrb         (fm_wstrb),
    .bus_addr      (fm_addr),
    .rdata_shifted (rdata_shifted)
  );

  // A flush landing in the completing cycle still discards the result.
  assign cancel_eff = cancel | flush;
  assign resp = ((state == BRG_WAIT) & data_sram_data_ok) |
                ((state == BRG_REQ) & data_sram_addr_ok & data_sram_data_ok);

  always_comb begin
    state_nxt     = state;
    cancel_nxt    = cancel;
    stall_req     = 1'b0;
    data_sram_req = 1'b0;
    capture       = 1'b0;
    unique case (state)
      BRG_IDLE: begin
        stall_req = data_ram_en & ~flush;
        if (data_ram_en & ~flush) begin
          capture   = 1'b1;
          state_nxt = BRG_REQ;
        end
      end
      BRG_REQ: begin
        data_sram_req = 1'b1;
        stall_req     = ~cancel_eff;
        cancel_nxt    = cancel_eff;
        if (data_sram_addr_ok) state_nxt = BRG_WAIT;
      end
      BRG_WAIT: begin
        stall_req  = ~cancel_eff;
        cancel_nxt = cancel_eff;
      end
      BRG_DONE: state_nxt = BRG_IDLE;
      default:  state_nxt = BRG_IDLE;
    endcase
    if (resp) begin
      state_nxt  = cancel_eff ? BRG_IDLE : BRG_DONE;
      cancel_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= BRG_IDLE;
      cancel <= 1'b0;
    end else begin
      state  <= state_nxt;
      cancel <= cancel_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sram_wr    <= 1'b0;
      data_sram_size  <= 2'd0;
      data_sram_addr  <= 32'd0;
      data_sram_wstrb <= 4'd0;
      data_sram_wdata <= 32'd0;
      off_q           <= 2'd0;
    end else if (capture) begin
      data_sram_wr    <= fm_wr;
      data_sram_size  <= fm_size;
      data_sram_addr  <= fm_addr;
      data_sram_wstrb <= fm_wstrb;
      data_sram_wdata <= data_ram_wdata;
      off_q           <= data_ram_addr[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_ram_rdata <= 32'd0;
    else if (resp & ~cancel_eff & ~data_sram_wr) data_ram_rdata <= rdata_shifted;
  end

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Randomized bench for lsu_sram_bridge against a transaction-level model.
module tb_lsu_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic [31:0] data_ram_addr, data_ram_wdata, data_ram_rdata;
  logic        flush, stall_req;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_rdata = 32'd0;

  always #5 clk = ~clk;

  lsu_sram_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .data_ram_en       (data_ram_en),
    .data_ram_wen      (data_ram_wen),
    .data_ram_addr     (data_ram_addr),
    .data_ram_wdata    (data_ram_wdata),
    .data_ram_rdata    (data_ram_rdata),
    .flush             (flush),
    .stall_req         (stall_req),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_size(input logic [3:0] wen);
    case ($countones(wen))
      1:       return 2'd0;
      2:       return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input logic [3:0] wen, input logic [31:0] addr);
    logic [7:0] wide;
    wide = {4'b0000, wen} << addr[1:0];
    return wide[3:0];
  endfunction

  // One access: a_dly REQ cycles before addr_ok, d_dly WAIT cycles before
  // data_ok, optional flush on REQ/WAIT cycle flush_at (-1 = none).
  task automatic run_access(input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int a_dly, input int d_dly, input int flush_at);
    int cyc, reqc, waitc, stalls;
    bit in_wait, cancelled, done;
    logic [31:0] e_addr, prev;
    prev   = model_rdata;
    e_addr = (wen == 4'd0) ? (addr & ~32'h3) : addr;
    @(negedge clk);
    data_ram_en = 1'b1; data_ram_wen = wen; data_ram_addr = addr; data_ram_wdata = wdata;
    flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    #1;
    chk("idle_stall", {31'd0, stall_req}, 32'd1);
    chk("idle_req", {31'd0, data_sram_req}, 32'd0);
    stalls = 1;
    cyc = 0; reqc = 0; waitc = 0; in_wait = 0; cancelled = 0; done = 0;
    @(negedge clk);
    while (!done && cyc < 100) begin
      flush = (cyc == flush_at);
      if (flush) begin
        cancelled   = 1;
        data_ram_en = 1'b0;
      end
      data_sram_addr_ok = !in_wait && (reqc == a_dly);
      data_sram_data_ok = in_wait && (waitc == d_dly);
      data_sram_rdata   = data_sram_data_ok ? rdata : $urandom;
      #1;
      chk("busy_stall", {31'd0, stall_req}, {31'd0, !cancelled});
      chk("busy_req", {31'd0, data_sram_req}, {31'd0, !in_wait});
      if (stall_req) stalls++;
      if (!in_wait) begin
        chk("req_wr", {31'd0, data_sram_wr}, {31'd0, wen != 4'd0});
        chk("req_size", {30'd0, data_sram_size}, {30'd0, exp_size(wen)});
        chk("req_addr", data_sram_addr, e_addr);
        chk("req_wstrb", {28'd0, data_sram_wstrb}, {28'd0, exp_strb(wen, addr)});
        chk("req_wdata", data_sram_wdata, wdata);
      end
      if (data_sram_data_ok) done = 1;
      if (in_wait) waitc++;
      else if (data_sram_addr_ok) in_wait = 1;
      else reqc++;
      cyc++;
      @(negedge clk);
    end
    if (!done) chk("bus_timeout", 32'd0, 32'd1);
    flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    data_sram_rdata = $urandom;
    if (!cancelled) begin
      if (wen == 4'd0) model_rdata = rdata >> (8 * addr[1:0]);
      flush = ($urandom_range(0, 1) == 1);
      #1;
      chk("done_stall", {31'd0, stall_req}, 32'd0);
      chk("done_req", {31'd0, data_sram_req}, 32'd0);
      chk("done_rdata", data_ram_rdata, model_rdata);
      chk("stall_cycles", stalls, 3 + a_dly + d_dly);
      @(negedge clk);
      flush = 1'b0;
      data_ram_en = 1'b0;
      #1;
      chk("post_req", {31'd0, data_sram_req}, 32'd0);
      chk("post_rdata", data_ram_rdata, model_rdata);
    end else begin
      data_ram_en = 1'b0;
      #1;
      chk("cancel_stall", {31'd0, stall_req}, 32'd0);
      chk("cancel_req", {31'd0, data_sram_req}, 32'd0);
      chk("cancel_rdata", data_ram_rdata, prev);
      @(negedge clk);
      #1;
      chk("cancel_idle_req", {31'd0, data_sram_req}, 32'd0);
    end
  endtask

  initial begin
    logic [3:0]  wen;
    logic [31:0] addr;
    int a, d, f;
    rst = 1'b1;
    data_ram_en = 1'b0; data_ram_wen = 4'd0; data_ram_addr = 32'd0; data_ram_wdata = 32'd0;
    flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
    #12;
    chk("rst_req", {31'd0, data_sram_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_rdata", data_ram_rdata, 32'd0);
    chk("rst_addr", data_sram_addr, 32'd0);
    chk("rst_wstrb", {28'd0, data_sram_wstrb}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_access(4'b0000, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0, -1);
    run_access(4'b0001, 32'h0000_2003, 32'h5A5A_5A5A, 32'h0, 0, 0, -1);
    run_access(4'b0000, 32'h0000_3002, 32'h0, 32'h1122_3344, 0, 0, -1);
    run_access(4'b0000, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 4, 3, -1);
    run_access(4'b0000, 32'h0000_5000, 32'h0, 32'h7777_8888, 3, 2, 1);

    // flush in IDLE: no request issued
    @(negedge clk);
    data_ram_en = 1'b1; data_ram_wen = 4'd0; data_ram_addr = 32'h6000; flush = 1'b1;
    #1;
    chk("idle_flush_stall", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    data_ram_en = 1'b0; flush = 1'b0;
    #1;
    chk("idle_flush_req", {31'd0, data_sram_req}, 32'd0);

    // async reset while in WAIT
    @(negedge clk);
    data_ram_en = 1'b1; data_ram_wen = 4'd0; data_ram_addr = 32'h7000;
    @(negedge clk);
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0; data_ram_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("wait_rst_req", {31'd0, data_sram_req}, 32'd0);
    chk("wait_rst_stall", {31'd0, stall_req}, 32'd0);
    chk("wait_rst_rdata", data_ram_rdata, 32'd0);
    model_rdata = 32'd0;
    #1 rst = 1'b0;
    run_access(4'b0000, 32'h0000_1004, 32'h0, 32'h0BAD_F00D, 0, 0, -1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       wen = 4'b0000;
        1:       wen = 4'b0001;
        2:       wen = 4'b0011;
        default: wen = 4'b1111;
      endcase
      addr = $urandom;
      if (wen == 4'b0011) addr[0] = 1'b0;
      if (wen == 4'b1111) addr[1:0] = 2'b00;
      a = $urandom_range(0, 4);
      d = $urandom_range(0, 3);
      f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, a + d + 1) : -1;
      run_access(wen, addr, $urandom, $urandom, a, d, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
